mult_axil_responder: RTL and testbench

//  AXI4-Lite slave that fronts a sequential shift-add multiplier. It sits behind the

---
 rtl/mult_axil_pkg.sv | 29 ++
 rtl/mult_axil_responder_if.sv | 45 ++++
 rtl/mult_axil_responder_seq_mult_core.sv | 78 +++++++
 rtl/mult_axil_responder.sv | 181 ++++++++++++++++++
 tb/tb_mult_axil_responder.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_axil_pkg.sv
// Register map, control-bit positions and shared types for the AXI4-Lite multiplier responder.
package mult_axil_pkg;

    // Word indices (ADDR[3:2]) of the byte offsets 0x0, 0x4, 0x8, 0xC
    localparam logic [1:0] OFS_OPA    = 2'd0;
    localparam logic [1:0] OFS_OPB    = 2'd1;
    localparam logic [1:0] OFS_CTRL   = 2'd2;
    localparam logic [1:0] OFS_RESULT = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_IE    = 1;
    localparam int CTRL_CLR   = 2;
    localparam int CTRL_BUSY  = 0;
    localparam int CTRL_DONE  = 2;
    localparam int CTRL_OVR   = 3;

    typedef enum logic [1:0] {RESP_OKAY = 2'b00} axi_resp_e;

    typedef enum logic {IDLE, RUN} fsm_state_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
        return (old_v & ~m) | (new_v & m);
    endfunction

endpackage

// File: rtl/mult_axil_responder_if.sv
// AXI4-Lite S00_AXI bundle; the responder takes the slave modport, the bus master the master modport.
interface mult_axil_responder_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/mult_axil_responder_seq_mult_core.sv
// Unsigned shift-add multiplier: one partial product per cycle for OP_WIDTH cycles.
module seq_mult_core
    import mult_axil_pkg::*;
#(
    parameter int OP_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [OP_WIDTH-1:0]     a_i,
    input  logic [OP_WIDTH-1:0]     b_i,
    output logic                    busy_o,
    output logic                    done_pulse_o,
    output logic [2*OP_WIDTH-1:0]   product_o
);
    localparam int PROD_W = 2 * OP_WIDTH;
    localparam int CNT_W  = $clog2(OP_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OP_WIDTH - 1);

    fsm_state_e          state_q, state_d;
    logic [OP_WIDTH-1:0] mplier_q, mplier_d;
    logic [PROD_W-1:0]   mcand_q, mcand_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   sum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // The final sum is exposed combinationally so the caller can capture it on the last RUN edge
    assign sum       = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product_o = sum;
    assign busy_o    = (state_q == RUN);

    always_comb begin
        state_d      = state_q;
        mplier_d     = mplier_q;
        mcand_d      = mcand_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        done_pulse_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = RUN;
                    mplier_d = a_i;
                    mcand_d  = PROD_W'(b_i);
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                acc_d    = sum;
                mplier_d = mplier_q >> 1;
                mcand_d  = mcand_q << 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d      = IDLE;
                    done_pulse_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: rtl/mult_axil_responder.sv
// AXI4-Lite register front end (OPA, OPB, CTRL, RESULT) for the sequential multiplier core.
module mult_axil_responder
    import mult_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int OP_WIDTH           = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    mult_axil_responder_if.slave s_axi,
    output logic                 irq
);
    localparam int PROD_W = 2 * OP_WIDTH;

    logic                          aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [1:0]                    waddr_q, waddr_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]                    wstrb_q, wstrb_d;
    logic                          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [OP_WIDTH-1:0]           opa_q, opa_d, opb_q, opb_d;
    logic                          ie_q, ie_d, done_q, done_d, ovr_q, ovr_d;
    logic [PROD_W-1:0]             result_q, result_d;

    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
    logic                          awready, wready, arready, aw_hs, w_hs, ar_hs;
    logic                          commit, wr_ctrl, start_req, clr_req;
    logic                          core_start, core_busy, core_done;
    logic [PROD_W-1:0]             core_product;
    logic [31:0]                   merge_a, merge_b;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
    logic                          unused_ok;

    assign awaddr  = s_axi.S_AXI_AWADDR;
    assign araddr  = s_axi.S_AXI_ARADDR;
    assign awready = ARESETN && !aw_held_q && !bvalid_q;
    assign wready  = ARESETN && !w_held_q && !bvalid_q;
    assign arready = ARESETN && !rvalid_q;
    assign aw_hs   = s_axi.S_AXI_AWVALID && awready;
    assign w_hs    = s_axi.S_AXI_WVALID && wready;
    assign ar_hs   = s_axi.S_AXI_ARVALID && arready;

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = RESP_OKAY;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;
    assign irq                 = done_q && ie_q;

    assign commit     = aw_held_q && w_held_q;
    assign wr_ctrl    = commit && (waddr_q == OFS_CTRL) && wstrb_q[0];
    assign start_req  = wr_ctrl && wdata_q[CTRL_START];
    assign clr_req    = wr_ctrl && wdata_q[CTRL_CLR];
    assign core_start = start_req && !core_busy;
    assign merge_a    = strb_merge(32'(opa_q), wdata_q, wstrb_q);
    assign merge_b    = strb_merge(32'(opb_q), wdata_q, wstrb_q);
    assign unused_ok  = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, awaddr[1:0], araddr[1:0],
                          merge_a, merge_b};

    seq_mult_core #(.OP_WIDTH(OP_WIDTH)) u_core (
        .clk_i        (ACLK),
        .rst_ni       (ARESETN),
        .start_i      (core_start),
        .a_i          (opa_q),
        .b_i          (opb_q),
        .busy_o       (core_busy),
        .done_pulse_o (core_done),
        .product_o    (core_product)
    );

    always_comb begin
        rd_word = '0;
        case (araddr[3:2])
            OFS_OPA:  rd_word[OP_WIDTH-1:0] = opa_q;
            OFS_OPB:  rd_word[OP_WIDTH-1:0] = opb_q;
            OFS_CTRL: begin
                rd_word[CTRL_BUSY] = core_busy;
                rd_word[CTRL_IE]   = ie_q;
                rd_word[CTRL_DONE] = done_q;
                rd_word[CTRL_OVR]  = ovr_q;
            end
            default:  rd_word[PROD_W-1:0] = result_q;
        endcase
    end

    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        ie_d      = ie_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        result_d  = result_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            waddr_d   = awaddr[3:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.S_AXI_WDATA;
            wstrb_d  = s_axi.S_AXI_WSTRB;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (waddr_q == OFS_OPA) opa_d = merge_a[OP_WIDTH-1:0];
            if (waddr_q == OFS_OPB) opb_d = merge_b[OP_WIDTH-1:0];
        end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        // clr is applied before start; a core completion on the same edge wins over both
        if (wr_ctrl) ie_d = wdata_q[CTRL_IE];
        if (clr_req) begin
            done_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (start_req) begin
            if (core_busy) ovr_d = 1'b1;
            else           done_d = 1'b0;
        end
        if (core_done) begin
            done_d   = 1'b1;
            result_d = core_product;
        end

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
        end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            ie_q      <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            result_q  <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            ie_q      <= ie_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            result_q  <= result_d;
        end
    end
endmodule

// File: tb/tb_mult_axil_responder.sv
// Directed bench for mult_axil_responder: vector table for products plus hand-written handshake/reset sequences.
module tb_mult_axil_responder;
    import mult_axil_pkg::*;

    localparam logic [3:0] A_OPA  = 4'h0;
    localparam logic [3:0] A_OPB  = 4'h4;
    localparam logic [3:0] A_CTRL = 4'h8;
    localparam logic [3:0] A_RES  = 4'hC;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        irq;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          commit_cyc = 0;
    logic        irq_at_commit;
    logic [1:0]  last_bresp;
    logic [31:0] rd;
    vec_t        vecs [8];

    mult_axil_responder_if bus ();

    mult_axil_responder #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .OP_WIDTH           (16)
    ) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .s_axi   (bus),
        .irq     (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_now, w_now;
        int n = 0;
        @(negedge clk);
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_now = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_now  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(negedge clk);
            if (aw_now) begin aw_done = 1'b1; bus.S_AXI_AWVALID = 1'b0; end
            if (w_now)  begin w_done  = 1'b1; bus.S_AXI_WVALID  = 1'b0; end
            n++;
        end
        if (!(aw_done && w_done)) begin
            timeout("write_accept");
            bus.S_AXI_AWVALID = 1'b0;
            bus.S_AXI_WVALID  = 1'b0;
            bus.S_AXI_BREADY  = 1'b0;
            return;
        end
        n = 0;
        while (!bus.S_AXI_BVALID && n < 20) begin @(negedge clk); n++; end
        if (!bus.S_AXI_BVALID) begin
            timeout("write_resp");
            bus.S_AXI_BREADY = 1'b0;
            return;
        end
        commit_cyc    = cyc;
        irq_at_commit = irq;
        last_bresp    = bus.S_AXI_BRESP;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n = 0;
        data = '0;
        @(negedge clk);
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        while (!bus.S_AXI_ARREADY && n < 20) begin @(negedge clk); n++; end
        if (!bus.S_AXI_ARREADY) begin
            timeout("read_accept");
            bus.S_AXI_ARVALID = 1'b0;
            return;
        end
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!bus.S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
        if (!bus.S_AXI_RVALID) begin
            timeout("read_resp");
            return;
        end
        data = bus.S_AXI_RDATA;
        bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic wait_idle(output logic [31:0] ctrl);
        int n = 0;
        axi_read(A_CTRL, ctrl);
        while (ctrl[0] && n < 20) begin axi_read(A_CTRL, ctrl); n++; end
        if (ctrl[0]) timeout("busy_clear");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2] = '{16'h0000, 16'hFFFF, 32'h0000_0000};
        vecs[3] = '{16'h1234, 16'h0010, 32'h0001_2340};
        vecs[4] = '{16'h8000, 16'h0002, 32'h0001_0000};
        vecs[5] = '{16'h00FF, 16'h00FF, 32'h0000_FE01};
        vecs[6] = '{16'hFFFF, 16'h0002, 32'h0001_FFFE};
        vecs[7] = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001};

        rst_n = 1'b0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_readies", {31'd0, bus.S_AXI_AWREADY | bus.S_AXI_WREADY | bus.S_AXI_ARREADY}, 32'd0);
        chk("rst_valids_irq", {29'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID, irq}, 32'd0);
        rst_n = 1'b1;

        // Reset values and byte strobes
        axi_read(A_OPA, rd);  chk("rst_opa", rd, 32'h0);
        axi_read(A_CTRL, rd); chk("rst_ctrl", rd, 32'h0);
        axi_read(A_RES, rd);  chk("rst_result", rd, 32'h0);
        axi_write(A_OPA, 32'hAABB_CCDD, 4'b0011);
        axi_read(A_OPA, rd);  chk("strb_low", rd, 32'h0000_CCDD);
        axi_write(A_OPA, 32'h0000_1100, 4'b0010);
        axi_read(A_OPA, rd);  chk("strb_byte1", rd, 32'h0000_11DD);
        axi_write(A_OPA, 32'hFFFF_FFFF, 4'b1100);
        axi_read(A_OPA, rd);  chk("strb_upper", rd, 32'h0000_11DD);
        axi_write(A_OPB, 32'hDEAD_BEEF, 4'b1111);
        axi_read(A_OPB, rd);  chk("opb_trunc", rd, 32'h0000_BEEF);

        // Product table
        for (int i = 0; i < 8; i++) begin
            axi_write(A_OPA, {16'h0, vecs[i].a}, 4'hF);
            axi_write(A_OPB, {16'h0, vecs[i].b}, 4'hF);
            axi_write(A_CTRL, 32'h1, 4'hF);
            axi_read(A_CTRL, rd); chk($sformatf("vec%0d_busy", i), rd, 32'h1);
            wait_idle(rd);        chk($sformatf("vec%0d_done", i), rd, 32'h4);
            axi_read(A_RES, rd);  chk($sformatf("vec%0d_result", i), rd, vecs[i].p);
        end

        axi_write(A_RES, 32'h0000_FFFF, 4'hF);
        chk("result_wr_bresp", {30'd0, last_bresp}, 32'h0);
        axi_read(A_RES, rd);  chk("result_ro", rd, 32'h3FFF_0001);

        // Overrun: restart and operand write during RUN leave the running op alone
        axi_write(A_OPA, 32'h3, 4'hF);
        axi_write(A_OPB, 32'h7, 4'hF);
        axi_write(A_CTRL, 32'h1, 4'hF);
        axi_write(A_OPA, 32'h9, 4'hF);
        axi_write(A_CTRL, 32'h1, 4'hF);
        wait_idle(rd);        chk("ovr_ctrl", rd, 32'hC);
        axi_read(A_RES, rd);  chk("ovr_result", rd, 32'h15);
        axi_write(A_CTRL, 32'h4, 4'hF);
        axi_read(A_CTRL, rd); chk("clr_ctrl", rd, 32'h0);
        axi_write(A_CTRL, 32'h5, 4'hF);
        axi_read(A_CTRL, rd); chk("clr_start_idle", rd, 32'h1);
        axi_write(A_CTRL, 32'h5, 4'hF);
        axi_read(A_CTRL, rd); chk("clr_start_busy", rd, 32'h9);
        wait_idle(rd);        chk("clr_start_done", rd, 32'hC);
        axi_read(A_RES, rd);  chk("clr_start_result", rd, 32'h3F);
        axi_write(A_CTRL, 32'h4, 4'hF);

        // B held by BREADY=0
        @(negedge clk);
        bus.S_AXI_AWADDR = A_OPB; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h1234; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b0;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bhold_%0d", i),
                {29'd0, bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'h4);
            @(negedge clk);
        end
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        chk("bhold_release", {31'd0, bus.S_AXI_BVALID}, 32'h0);
        bus.S_AXI_BREADY = 1'b0;
        axi_read(A_OPB, rd);  chk("bhold_data", rd, 32'h1234);

        // W two cycles ahead of AW
        @(negedge clk);
        bus.S_AXI_WDATA = 32'h77; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b0;
        chk("wfirst_wready", {31'd0, bus.S_AXI_WREADY}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("wfirst_no_b", {31'd0, bus.S_AXI_BVALID}, 32'h0);
        bus.S_AXI_AWADDR = A_OPA; bus.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        @(negedge clk);
        chk("wfirst_b", {31'd0, bus.S_AXI_BVALID}, 32'h1);
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        axi_read(A_OPA, rd);  chk("wfirst_data", rd, 32'h77);

        // R held by RREADY=0
        @(negedge clk);
        bus.S_AXI_ARADDR = A_OPB; bus.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rhold_flags_%0d", i), {30'd0, bus.S_AXI_RVALID, bus.S_AXI_ARREADY}, 32'h2);
            chk($sformatf("rhold_data_%0d", i), bus.S_AXI_RDATA, 32'h1234);
            @(negedge clk);
        end
        bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
        chk("rhold_release", {31'd0, bus.S_AXI_RVALID}, 32'h0);

        // Reset during RUN with a B and an R response both pending
        axi_write(A_OPA, 32'h5, 4'hF);
        axi_write(A_OPB, 32'h6, 4'hF);
        axi_write(A_CTRL, 32'h3, 4'hF);
        @(negedge clk);
        bus.S_AXI_AWADDR = A_OPA; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h55; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        @(negedge clk);
        bus.S_AXI_ARADDR = A_CTRL; bus.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        chk("pre_rst_pending", {30'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'h3);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {26'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_AWREADY,
                               bus.S_AXI_WREADY, bus.S_AXI_ARREADY, irq}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_no_resp", {30'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'h0);
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        axi_read(A_OPA, rd);  chk("post_rst_opa", rd, 32'h0);
        axi_read(A_OPB, rd);  chk("post_rst_opb", rd, 32'h0);
        axi_read(A_CTRL, rd); chk("post_rst_ctrl", rd, 32'h0);
        axi_read(A_RES, rd);  chk("post_rst_result", rd, 32'h0);

        // Interrupt timing, ie gating and clear
        axi_write(A_OPA, 32'h2, 4'hF);
        axi_write(A_OPB, 32'h3, 4'hF);
        axi_write(A_CTRL, 32'h2, 4'hF);
        axi_write(A_CTRL, 32'h3, 4'hF);
        begin
            int n = 0;
            while (!irq && n < 40) begin @(negedge clk); n++; end
            if (!irq) timeout("irq_rise");
            else      chk("irq_latency", 32'(cyc - commit_cyc), 32'd16);
        end
        axi_read(A_CTRL, rd); chk("irq_ctrl", rd, 32'h6);
        axi_read(A_RES, rd);  chk("irq_result", rd, 32'h6);
        axi_write(A_CTRL, 32'h0, 4'hF);
        chk("irq_ie_off", {31'd0, irq_at_commit}, 32'h0);
        axi_read(A_CTRL, rd); chk("irq_done_kept", rd, 32'h4);
        axi_write(A_CTRL, 32'h2, 4'hF);
        chk("irq_ie_on", {31'd0, irq}, 32'h1);
        axi_write(A_CTRL, 32'h6, 4'hF);
        chk("irq_clr", {31'd0, irq_at_commit}, 32'h0);
        axi_read(A_CTRL, rd); chk("irq_clr_ctrl", rd, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
